// File: rtl/fp_pkg.sv
// Shared constants, operand classification and helpers for the pipelined FP adder.
package fp_pkg;

    localparam int FLG_INV  = 3;
    localparam int FLG_OVF  = 2;
    localparam int FLG_UNF  = 1;
    localparam int FLG_INX  = 0;
    localparam int FP_MAX_W = 128;

    typedef enum logic [2:0] {
        CLS_ZERO = 3'd0,
        CLS_NORM = 3'd1,
        CLS_INF  = 3'd2,
        CLS_QNAN = 3'd3,
        CLS_SNAN = 3'd4
    } fp_class_e;

    function automatic int fp_w(input int exp_w, input int man_w);
        return 1 + exp_w + man_w;
    endfunction

    // Subnormals (exp == 0) classify as zero so they flush on unpack.
    function automatic fp_class_e fp_classify(input logic exp_zero, input logic exp_ones,
                                              input logic frac_zero, input logic frac_msb);
        fp_class_e cls;
        if (exp_zero) begin
            cls = CLS_ZERO;
        end else if (!exp_ones) begin
            cls = CLS_NORM;
        end else if (frac_zero) begin
            cls = CLS_INF;
        end else if (frac_msb) begin
            cls = CLS_QNAN;
        end else begin
            cls = CLS_SNAN;
        end
        return cls;
    endfunction

    function automatic logic [FP_MAX_W-1:0] fp_qnan(input int exp_w, input int man_w);
        logic [FP_MAX_W-1:0] v;
        v = '0;
        for (int i = 0; i < FP_MAX_W; i++) begin
            if (i == man_w - 1) begin
                v[i] = 1'b1;
            end else if (i >= man_w && i < man_w + exp_w) begin
                v[i] = 1'b1;
            end else begin
                v[i] = 1'b0;
            end
        end
        return v;
    endfunction

endpackage

// File: rtl/fp_lzc.sv
// Parametrised leading-zero counter; an all-zero vector returns WIDTH.
module fp_lzc #(
    parameter int  WIDTH = 28,
    localparam int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic [WIDTH-1:0] vec,
    output logic [CNT_W-1:0] count
);

    logic found_s;

    // Scan from the MSB, counting zeros until the first set bit.
    always_comb begin
        count   = '0;
        found_s = 1'b0;
        for (int i = WIDTH - 1; i >= 0; i--) begin
            if (!found_s) begin
                if (vec[i]) begin
                    found_s = 1'b1;
                end else begin
                    count = count + {{(CNT_W-1){1'b0}}, 1'b1};
                end
            end else begin
                found_s = 1'b1;
            end
        end
    end

endmodule

// File: rtl/fp_addsub_pipe.sv
// Three-stage pipelined floating-point adder/subtractor with valid/ready on both ports.
// Special operands are resolved at unpack and travel past the datapath as a bypass.
module fp_addsub_pipe
    import fp_pkg::*;
#(
    parameter int  EXP_W = 8,
    parameter int  MAN_W = 23,
    localparam int W     = fp_w(EXP_W, MAN_W)
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         sub,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] result,
    output logic [3:0]   flags
);

    localparam int SW  = MAN_W + 4;
    localparam int CW  = MAN_W + 5;
    localparam int LZW = $clog2(CW + 1);
    localparam int XW  = EXP_W + $clog2(MAN_W + 6) + 2;
    localparam logic [EXP_W-1:0]      EXP_ONES  = {EXP_W{1'b1}};
    localparam logic [W-1:0]          QNAN      = W'(fp_qnan(EXP_W, MAN_W));
    localparam logic signed [XW-1:0] X_ONE     = {{(XW-1){1'b0}}, 1'b1};
    localparam logic signed [XW-1:0] X_ZERO    = {XW{1'b0}};
    localparam logic signed [XW-1:0] X_EXP_MAX = {{(XW-EXP_W){1'b0}}, EXP_ONES};

    logic             s1_valid_r, s1_sign_r, s1_sub_r, s1_byp_r;
    logic [EXP_W-1:0] s1_exp_r;
    logic [SW-1:0]    s1_big_r, s1_small_r;
    logic [W-1:0]     s1_byp_res_r;
    logic [3:0]       s1_byp_flg_r;

    logic             s2_valid_r, s2_sign_r, s2_byp_r;
    logic [EXP_W-1:0] s2_exp_r;
    logic [CW-1:0]    s2_sum_r;
    logic [W-1:0]     s2_byp_res_r;
    logic [3:0]       s2_byp_flg_r;

    logic             s3_valid_r;
    logic [W-1:0]     result_r;
    logic [3:0]       flags_r;

    logic en1_s, en2_s, en3_s;

    assign en3_s     = !s3_valid_r || out_ready;
    assign en2_s     = !s2_valid_r || en3_s;
    assign en1_s     = !s1_valid_r || en2_s;
    assign in_ready  = en1_s;
    assign out_valid = s3_valid_r;
    assign result    = result_r;
    assign flags     = flags_r;

    logic             sa_s, sb_s, a_norm_s, b_norm_s;
    logic [EXP_W-1:0] ea_s, eb_s;
    logic [MAN_W-1:0] fa_s, fb_s;
    fp_class_e        ca_s, cb_s;
    logic [EXP_W+MAN_W-1:0] mag_a_s, mag_b_s;
    logic [SW-1:0]    sig_a_s, sig_b_s;

    assign sa_s     = a[W-1];
    assign ea_s     = a[W-2:MAN_W];
    assign fa_s     = a[MAN_W-1:0];
    assign sb_s     = b[W-1] ^ sub;
    assign eb_s     = b[W-2:MAN_W];
    assign fb_s     = b[MAN_W-1:0];
    assign ca_s     = fp_classify(ea_s == '0, ea_s == EXP_ONES, fa_s == '0, fa_s[MAN_W-1]);
    assign cb_s     = fp_classify(eb_s == '0, eb_s == EXP_ONES, fb_s == '0, fb_s[MAN_W-1]);
    assign a_norm_s = (ca_s == CLS_NORM);
    assign b_norm_s = (cb_s == CLS_NORM);
    assign mag_a_s  = a_norm_s ? {ea_s, fa_s} : '0;
    assign mag_b_s  = b_norm_s ? {eb_s, fb_s} : '0;
    assign sig_a_s  = a_norm_s ? {1'b1, fa_s, 3'b000} : '0;
    assign sig_b_s  = b_norm_s ? {1'b1, fb_s, 3'b000} : '0;

    logic             big_sign_s;
    logic [EXP_W-1:0] big_exp_s, small_exp_s, diff_s;
    logic [SW-1:0]    big_sig_s, small_ext_s, small_al_s;
    logic [2*SW-1:0]  wide_s;

    // Swap so the larger magnitude is the big operand, then align the small one with sticky.
    always_comb begin
        if (mag_a_s >= mag_b_s) begin
            big_sign_s  = sa_s;
            big_exp_s   = a_norm_s ? ea_s : '0;
            small_exp_s = b_norm_s ? eb_s : '0;
            big_sig_s   = sig_a_s;
            small_ext_s = sig_b_s;
        end else begin
            big_sign_s  = sb_s;
            big_exp_s   = b_norm_s ? eb_s : '0;
            small_exp_s = a_norm_s ? ea_s : '0;
            big_sig_s   = sig_b_s;
            small_ext_s = sig_a_s;
        end
        diff_s = big_exp_s - small_exp_s;
        wide_s = {small_ext_s, {SW{1'b0}}} >> diff_s;
        if (32'(diff_s) >= MAN_W + 3) begin
            small_al_s = {{(SW-1){1'b0}}, |small_ext_s};
        end else begin
            small_al_s = wide_s[2*SW-1:SW] | {{(SW-1){1'b0}}, |wide_s[SW-1:0]};
        end
    end

    logic         byp_s;
    logic [W-1:0] byp_res_s;
    logic [3:0]   byp_flg_s;

    // Resolve NaN, infinity and zero-plus-zero operands ahead of the datapath.
    always_comb begin
        byp_s     = 1'b1;
        byp_res_s = '0;
        byp_flg_s = 4'b0000;
        if (ca_s == CLS_QNAN || ca_s == CLS_SNAN || cb_s == CLS_QNAN || cb_s == CLS_SNAN) begin
            byp_res_s          = QNAN;
            byp_flg_s[FLG_INV] = (ca_s == CLS_SNAN) || (cb_s == CLS_SNAN);
        end else if (ca_s == CLS_INF && cb_s == CLS_INF) begin
            if (sa_s != sb_s) begin
                byp_res_s          = QNAN;
                byp_flg_s[FLG_INV] = 1'b1;
            end else begin
                byp_res_s = {sa_s, EXP_ONES, {MAN_W{1'b0}}};
            end
        end else if (ca_s == CLS_INF) begin
            byp_res_s = {sa_s, EXP_ONES, {MAN_W{1'b0}}};
        end else if (cb_s == CLS_INF) begin
            byp_res_s = {sb_s, EXP_ONES, {MAN_W{1'b0}}};
        end else if (ca_s == CLS_ZERO && cb_s == CLS_ZERO) begin
            byp_res_s = {sa_s & sb_s, {(W-1){1'b0}}};
        end else begin
            byp_s = 1'b0;
        end
    end

    // Stage 1 register: aligned operands or bypass result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_r   <= 1'b0;
            s1_sign_r    <= 1'b0;
            s1_sub_r     <= 1'b0;
            s1_byp_r     <= 1'b0;
            s1_exp_r     <= '0;
            s1_big_r     <= '0;
            s1_small_r   <= '0;
            s1_byp_res_r <= '0;
            s1_byp_flg_r <= 4'b0000;
        end else if (en1_s) begin
            s1_valid_r <= in_valid;
            if (in_valid) begin
                s1_sign_r    <= big_sign_s;
                s1_sub_r     <= sa_s ^ sb_s;
                s1_byp_r     <= byp_s;
                s1_exp_r     <= big_exp_s;
                s1_big_r     <= big_sig_s;
                s1_small_r   <= small_al_s;
                s1_byp_res_r <= byp_res_s;
                s1_byp_flg_r <= byp_flg_s;
            end
        end
    end

    logic [CW-1:0] sum_s;

    // Big >= small by construction, so the subtraction never goes negative.
    always_comb begin
        if (s1_sub_r) begin
            sum_s = {1'b0, s1_big_r} - {1'b0, s1_small_r};
        end else begin
            sum_s = {1'b0, s1_big_r} + {1'b0, s1_small_r};
        end
    end

    // Stage 2 register: raw significand sum with carry bit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_valid_r   <= 1'b0;
            s2_sign_r    <= 1'b0;
            s2_byp_r     <= 1'b0;
            s2_exp_r     <= '0;
            s2_sum_r     <= '0;
            s2_byp_res_r <= '0;
            s2_byp_flg_r <= 4'b0000;
        end else if (en2_s) begin
            s2_valid_r <= s1_valid_r;
            if (s1_valid_r) begin
                s2_sign_r    <= s1_sign_r;
                s2_byp_r     <= s1_byp_r;
                s2_exp_r     <= s1_exp_r;
                s2_sum_r     <= sum_s;
                s2_byp_res_r <= s1_byp_res_r;
                s2_byp_flg_r <= s1_byp_flg_r;
            end
        end
    end

    logic [LZW-1:0]         lz_s, lzm1_s;
    logic [SW-1:0]          norm_s;
    logic signed [XW-1:0]   exp_x_s, exp_n_s, exp_r_s;
    logic [MAN_W+1:0]       mant_s;
    logic [MAN_W-1:0]       frac_s;
    logic                   inexact_s;
    logic [W-1:0]           res_s;
    logic [3:0]             flg_s;

    fp_lzc #(.WIDTH(CW)) u_lzc (
        .vec   (s2_sum_r),
        .count (lz_s)
    );

    assign lzm1_s  = lz_s - {{(LZW-1){1'b0}}, 1'b1};
    assign exp_x_s = $signed({{(XW-EXP_W){1'b0}}, s2_exp_r});

    // Normalise, round to nearest-even, then pack with overflow/underflow handling.
    always_comb begin
        if (s2_sum_r[CW-1]) begin
            norm_s  = {s2_sum_r[CW-1:2], s2_sum_r[1] | s2_sum_r[0]};
            exp_n_s = exp_x_s + X_ONE;
        end else begin
            norm_s  = s2_sum_r[SW-1:0] << lzm1_s;
            exp_n_s = exp_x_s - $signed({{(XW-LZW){1'b0}}, lzm1_s});
        end
        inexact_s = norm_s[2] | norm_s[1] | norm_s[0];
        mant_s    = {1'b0, norm_s[SW-1:3]}
                  + {{(MAN_W+1){1'b0}}, norm_s[2] & (norm_s[1] | norm_s[0] | norm_s[3])};
        if (mant_s[MAN_W+1]) begin
            exp_r_s = exp_n_s + X_ONE;
            frac_s  = mant_s[MAN_W:1];
        end else begin
            exp_r_s = exp_n_s;
            frac_s  = mant_s[MAN_W-1:0];
        end
        res_s = '0;
        flg_s = 4'b0000;
        if (s2_byp_r) begin
            res_s = s2_byp_res_r;
            flg_s = s2_byp_flg_r;
        end else if (s2_sum_r == '0) begin
            res_s = '0;
        end else if (exp_r_s >= X_EXP_MAX) begin
            res_s          = {s2_sign_r, EXP_ONES, {MAN_W{1'b0}}};
            flg_s[FLG_OVF] = 1'b1;
            flg_s[FLG_INX] = 1'b1;
        end else if (exp_r_s <= X_ZERO) begin
            res_s          = {s2_sign_r, {(W-1){1'b0}}};
            flg_s[FLG_UNF] = 1'b1;
            flg_s[FLG_INX] = 1'b1;
        end else begin
            res_s          = {s2_sign_r, exp_r_s[EXP_W-1:0], frac_s};
            flg_s[FLG_INX] = inexact_s;
        end
    end

    // Stage 3 register: output beat, held while the consumer stalls.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s3_valid_r <= 1'b0;
            result_r   <= '0;
            flags_r    <= 4'b0000;
        end else if (en3_s) begin
            s3_valid_r <= s2_valid_r;
            if (s2_valid_r) begin
                result_r <= res_s;
                flags_r  <= flg_s;
            end
        end
    end

endmodule

// File: tb/tb_fp_addsub_pipe.sv
// Scoreboard bench: drivers queue hand-computed results, monitors pop and compare on output beats.
module tb_fp_addsub_pipe;

    typedef struct {
        logic [31:0] res;
        logic [3:0]  flg;
        int          acc_cyc;
        bit          chk_lat;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid32 = 1'b0, in_ready32, sub32 = 1'b0, out_valid32, out_ready32 = 1'b1;
    logic [31:0] a32 = 32'h0, b32 = 32'h0, result32;
    logic [3:0]  flags32;
    logic        in_valid_h = 1'b0, in_ready_h, sub_h = 1'b0, out_valid_h, out_ready_h = 1'b1;
    logic [15:0] a_h = 16'h0, b_h = 16'h0, result_h;
    logic [3:0]  flags_h;

    int   checks = 0;
    int   failures = 0;
    int   cyc = 0;
    int   acc32 = 0;
    exp_t q32[$];
    exp_t qh[$];
    bit   hold_v = 1'b0;
    logic [31:0] hold_res;
    logic [3:0]  hold_flg;

    fp_addsub_pipe dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid32), .in_ready(in_ready32),
        .a(a32), .b(b32), .sub(sub32), .out_valid(out_valid32), .out_ready(out_ready32),
        .result(result32), .flags(flags32)
    );

    fp_addsub_pipe #(.EXP_W(5), .MAN_W(10)) dut_h (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid_h), .in_ready(in_ready_h),
        .a(a_h), .b(b_h), .sub(sub_h), .out_valid(out_valid_h), .out_ready(out_ready_h),
        .result(result_h), .flags(flags_h)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    task automatic send32(input logic [31:0] av, input logic [31:0] bv, input logic sv,
                          input logic [31:0] er, input logic [3:0] ef, input bit lat);
        exp_t e;
        bit   done;
        done = 1'b0;
        a32 = av; b32 = bv; sub32 = sv; in_valid32 = 1'b1;
        for (int k = 0; k < 64 && !done; k++) begin
            @(negedge clk);
            if (in_ready32) begin
                e.res = er; e.flg = ef; e.acc_cyc = cyc; e.chk_lat = lat;
                q32.push_back(e);
                acc32++;
                done = 1'b1;
            end
            @(posedge clk); #1;
        end
        if (!done) chk("accept_timeout32", 32'd0, 32'd1);
    endtask

    task automatic send_h(input logic [15:0] av, input logic [15:0] bv, input logic sv,
                          input logic [15:0] er, input logic [3:0] ef);
        exp_t e;
        bit   done;
        done = 1'b0;
        a_h = av; b_h = bv; sub_h = sv; in_valid_h = 1'b1;
        for (int k = 0; k < 64 && !done; k++) begin
            @(negedge clk);
            if (in_ready_h) begin
                e.res = {16'h0000, er}; e.flg = ef; e.acc_cyc = cyc; e.chk_lat = 1'b0;
                qh.push_back(e);
                done = 1'b1;
            end
            @(posedge clk); #1;
        end
        if (!done) chk("accept_timeout16", 32'd0, 32'd1);
    endtask

    task automatic drain();
        for (int k = 0; k < 200 && (q32.size() > 0 || qh.size() > 0); k++) @(negedge clk);
        if (q32.size() > 0 || qh.size() > 0) chk("drain_timeout", q32.size() + qh.size(), 32'd0);
        @(posedge clk); #1;
    endtask

    // Binary32 monitor: pops on each output transfer and checks result stability under stall.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n && out_valid32 && out_ready32) begin
            hold_v = 1'b0;
            if (q32.size() == 0) begin
                chk("unexpected_beat32", result32, 32'hxxxxxxxx);
            end else begin
                e = q32.pop_front();
                chk("result32", result32, e.res);
                chk("flags32", {28'h0, flags32}, {28'h0, e.flg});
                if (e.chk_lat) chk("latency32", cyc - e.acc_cyc, 32'd3);
            end
        end else if (rst_n && out_valid32) begin
            if (hold_v) begin
                chk("stall_result32", result32, hold_res);
                chk("stall_flags32", {28'h0, flags32}, {28'h0, hold_flg});
            end
            hold_v = 1'b1; hold_res = result32; hold_flg = flags32;
        end else begin
            hold_v = 1'b0;
        end
    end

    // Binary16 monitor.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n && out_valid_h && out_ready_h) begin
            if (qh.size() == 0) begin
                chk("unexpected_beat16", {16'h0, result_h}, 32'hxxxxxxxx);
            end else begin
                e = qh.pop_front();
                chk("result16", {16'h0, result_h}, e.res);
                chk("flags16", {28'h0, flags_h}, {28'h0, e.flg});
            end
        end
    end

    logic [31:0] bp_a [6] = '{32'h3F800000, 32'h40000000, 32'h3F800000, 32'h40000000, 32'h3F800000, 32'h40400000};
    logic [31:0] bp_b [6] = '{32'h3F800000, 32'h3F800000, 32'h3F000000, 32'h40000000, 32'h3F000000, 32'h3F800000};
    logic        bp_s [6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    logic [31:0] bp_r [6] = '{32'h40000000, 32'h40400000, 32'h3FC00000, 32'h40800000, 32'h3F000000, 32'h40800000};

    initial begin
        int gaps;
        int stale;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("rst_out_valid", {31'h0, out_valid32}, 32'd0);
        chk("rst_result", result32, 32'h0);
        chk("rst_flags", {28'h0, flags32}, 32'h0);
        chk("rst_in_ready", {31'h0, in_ready32}, 32'd1);
        @(posedge clk); #1;

        send32(32'h3F980000, 32'h3F100000, 1'b0, 32'h3FE00000, 4'b0000, 1'b1);
        send32(32'h3F980000, 32'h3F100000, 1'b1, 32'h3F200000, 4'b0000, 1'b0);
        send32(32'h3F800000, 32'h33800000, 1'b0, 32'h3F800000, 4'b0001, 1'b0);
        send32(32'h3F800001, 32'h33800000, 1'b0, 32'h3F800002, 4'b0001, 1'b0);
        send32(32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 32'h7F800000, 4'b0101, 1'b0);
        send32(32'h3F980000, 32'h3F980000, 1'b1, 32'h00000000, 4'b0000, 1'b0);
        send32(32'h7F800000, 32'h7F800000, 1'b1, 32'h7FC00000, 4'b1000, 1'b0);
        send32(32'h7F800001, 32'h3F800000, 1'b0, 32'h7FC00000, 4'b1000, 1'b0);
        send32(32'h7FC00000, 32'h3F800000, 1'b0, 32'h7FC00000, 4'b0000, 1'b0);
        send32(32'hFF800000, 32'h3F800000, 1'b0, 32'hFF800000, 4'b0000, 1'b0);
        send32(32'h80000000, 32'h80000000, 1'b0, 32'h80000000, 4'b0000, 1'b0);
        send32(32'h80000000, 32'h00000000, 1'b1, 32'h80000000, 4'b0000, 1'b0);
        send32(32'h00000000, 32'h80000000, 1'b0, 32'h00000000, 4'b0000, 1'b0);
        send32(32'h3F800000, 32'h20000000, 1'b0, 32'h3F800000, 4'b0001, 1'b0);
        send32(32'h00800001, 32'h00800000, 1'b1, 32'h00000000, 4'b0011, 1'b0);
        in_valid32 = 1'b0;
        drain();

        out_ready32 = 1'b0;
        acc32 = 0;
        fork
            begin
                repeat (5) @(negedge clk);
                chk("bp_in_ready_low", {31'h0, in_ready32}, 32'd0);
                chk("bp_accepted", acc32, 32'd3);
                @(posedge clk); #1;
                out_ready32 = 1'b1;
                gaps = 0;
                repeat (6) begin
                    @(negedge clk);
                    if (!out_valid32) gaps++;
                end
                chk("bp_gaps", gaps, 32'd0);
            end
            begin
                for (int i = 0; i < 6; i++) send32(bp_a[i], bp_b[i], bp_s[i], bp_r[i], 4'b0000, 1'b0);
                in_valid32 = 1'b0;
            end
        join
        drain();

        send_h(16'h3C00, 16'h3C00, 1'b0, 16'h4000, 4'b0000);
        send_h(16'h4200, 16'hC000, 1'b0, 16'h3C00, 4'b0000);
        send_h(16'h7BFF, 16'h7BFF, 1'b0, 16'h7C00, 4'b0101);
        in_valid_h = 1'b0;
        drain();

        send32(32'h3F800000, 32'h3F800000, 1'b0, 32'h40000000, 4'b0000, 1'b0);
        send32(32'h40000000, 32'h3F800000, 1'b0, 32'h40400000, 4'b0000, 1'b0);
        send32(32'h3F800000, 32'h3F000000, 1'b0, 32'h3FC00000, 4'b0000, 1'b0);
        in_valid32 = 1'b0;
        #1 rst_n = 1'b0;
        q32.delete();
        #1;
        chk("midrst_out_valid", {31'h0, out_valid32}, 32'd0);
        chk("midrst_result", result32, 32'h0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        stale = 0;
        repeat (8) begin
            @(negedge clk);
            if (out_valid32) stale++;
        end
        chk("midrst_stale_beats", stale, 32'd0);
        chk("midrst_in_ready", {31'h0, in_ready32}, 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
